// File: rtl/score_pkg.sv
// Shared constants, state encodings and helpers for the score/level display block.
package score_pkg;

    // Active-low seven-segment codes, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_S     = 8'h92;
    localparam logic [7:0] SEG_L     = 8'hC7;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Base points indexed by (lines cleared - 1), stored as a single BCD digit.
    localparam logic [3:0] BASE_PTS [0:3] = '{4'd1, 4'd3, 4'd5, 4'd8};

    typedef enum logic [1:0] {AdIdle, AdAdd, AdNext} add_state_e;
    typedef enum logic [1:0] {ShLoad, ShShift, ShGap} shift_state_e;

    // Non-decimal codes show as blank rather than garbage.
    function automatic logic [7:0] bcd2seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_serializer.sv
// Shifts a 64-bit segment frame MSB first to the serial segment driver, then idles a gap.
module seg_serializer
    import score_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned REFRESH_GAP = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] frame_i,
    output logic        seg_clk_o,
    output logic        seg_clr_o,
    output logic        seg_dt_o,
    output logic        seg_en_o
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(REFRESH_GAP - 1);

    shift_state_e    state_q, state_d;
    logic [63:0]     sh_q, sh_d;
    logic [5:0]      bit_q, bit_d;
    logic [DivW-1:0] div_q, div_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            sclk_q, sclk_d;
    logic            dt_q, dt_d;
    logic            clr_q, en_q;

    // Next-state: snapshot, clock-divided shift with data changing on the falling phase, gap.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        div_d   = div_q;
        gap_d   = gap_q;
        sclk_d  = sclk_q;
        dt_d    = dt_q;
        unique case (state_q)
            ShLoad: begin
                // Whole frame captured at once so a score update cannot tear the display.
                sh_d    = frame_i;
                dt_d    = frame_i[63];
                bit_d   = '0;
                div_d   = '0;
                sclk_d  = 1'b0;
                state_d = ShShift;
            end
            ShShift: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 6'd63) begin
                            dt_d    = 1'b0;
                            gap_d   = '0;
                            state_d = ShGap;
                        end else begin
                            bit_d = bit_q + 6'd1;
                            sh_d  = {sh_q[62:0], 1'b0};
                            dt_d  = sh_q[62];
                        end
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            ShGap: begin
                if (gap_q == GapLast) begin
                    state_d = ShLoad;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = ShLoad;
        endcase
    end

    // State register; clear and enable release to 1 on the first clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ShLoad;
            sh_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            gap_q   <= '0;
            sclk_q  <= 1'b0;
            dt_q    <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            gap_q   <= gap_d;
            sclk_q  <= sclk_d;
            dt_q    <= dt_d;
            clr_q   <= 1'b1;
            en_q    <= 1'b1;
        end
    end

    assign seg_clk_o = sclk_q;
    assign seg_dt_o  = dt_q;
    assign seg_clr_o = clr_q;
    assign seg_en_o  = en_q;

endmodule

// File: rtl/score_level_display.sv
// Saturating BCD score accumulator with level tracking and serial seven-segment output.
module score_level_display
    import score_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned REFRESH_GAP     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hit,
    input  logic [1:0]            lineCount,
    input  logic                  mode,
    output logic [4*DIGITS-1:0]   score,
    output logic [3:0]            level,
    output logic                  busy,
    output logic                  SEGCLK,
    output logic                  SEGCLR,
    output logic                  SEGDT,
    output logic                  SEGEN
);

    localparam logic [2:0] LastDig = 3'(DIGITS - 1);
    localparam logic [8:0] Lpl     = 9'(LINES_PER_LEVEL);

    add_state_e          state_q, state_d;
    logic [4*DIGITS-1:0] score_q, score_d;
    logic [3:0]          level_q, level_d;
    logic [7:0]          lines_q, lines_d;
    logic [3:0]          base_q, base_d;
    logic [1:0]          lc_q, lc_d;
    logic [3:0]          passes_q, passes_d;
    logic [2:0]          dig_q, dig_d;
    logic                carry_q, carry_d;
    logic                sat_q, sat_d;
    logic                pend_q, pend_d;
    logic [1:0]          pend_lc_q, pend_lc_d;

    logic                start;
    logic [1:0]          src_lc;
    logic [3:0]          cur, addend, digit;
    logic [4:0]          sum5;
    logic                cout;
    logic [8:0]          sum9;
    logic [63:0]         frame;

    // A waiting pending award takes priority over a fresh hit in IDLE.
    assign start  = (state_q == AdIdle) && (hit || pend_q);
    assign src_lc = pend_q ? pend_lc_q : lineCount;
    assign busy   = (state_q != AdIdle) || start;

    // Adder next-state: digit-serial BCD add repeated once per (level+1) pass.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        level_d   = level_q;
        lines_d   = lines_q;
        base_d    = base_q;
        lc_d      = lc_q;
        passes_d  = passes_q;
        dig_d     = dig_q;
        carry_d   = carry_q;
        sat_d     = sat_q;
        pend_d    = pend_q;
        pend_lc_d = pend_lc_q;

        cur    = score_q[4*dig_q +: 4];
        addend = (dig_q == 3'd0) ? base_q : 4'd0;
        sum5   = {1'b0, cur} + {1'b0, addend} + {4'd0, carry_q};
        cout   = (sum5 > 5'd9);
        digit  = cout ? 4'(sum5 - 5'd10) : sum5[3:0];
        sum9   = {1'b0, lines_q} + {7'd0, lc_q} + 9'd1;

        // One-deep slot: refilled as it drains, otherwise extra hits while busy are dropped.
        if (start && pend_q) begin
            pend_d    = hit;
            pend_lc_d = lineCount;
        end else if ((state_q != AdIdle) && hit && !pend_q) begin
            pend_d    = 1'b1;
            pend_lc_d = lineCount;
        end

        unique case (state_q)
            AdIdle: begin
                if (start) begin
                    base_d   = BASE_PTS[src_lc];
                    lc_d     = src_lc;
                    passes_d = level_q + 4'd1;
                    dig_d    = '0;
                    carry_d  = 1'b0;
                    state_d  = AdAdd;
                end
            end
            AdAdd: begin
                if (!sat_q) begin
                    score_d[4*dig_q +: 4] = digit;
                    carry_d = cout;
                end
                if (dig_q == LastDig) begin
                    if (cout && !sat_q) begin
                        score_d = {DIGITS{4'h9}};
                        sat_d   = 1'b1;
                    end
                    state_d = AdNext;
                end else begin
                    dig_d = dig_q + 3'd1;
                end
            end
            AdNext: begin
                passes_d = passes_q - 4'd1;
                dig_d    = '0;
                carry_d  = 1'b0;
                if (passes_q == 4'd1) begin
                    if (sum9 >= Lpl) begin
                        lines_d = 8'(sum9 - Lpl);
                        if (level_q != 4'd9) begin
                            level_d = level_q + 4'd1;
                        end
                    end else begin
                        lines_d = sum9[7:0];
                    end
                    state_d = AdIdle;
                end else begin
                    state_d = AdAdd;
                end
            end
            default: state_d = AdIdle;
        endcase
    end

    // Adder state register; reset discards any partial score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= AdIdle;
            score_q   <= '0;
            level_q   <= '0;
            lines_q   <= '0;
            base_q    <= '0;
            lc_q      <= '0;
            passes_q  <= '0;
            dig_q     <= '0;
            carry_q   <= 1'b0;
            sat_q     <= 1'b0;
            pend_q    <= 1'b0;
            pend_lc_q <= '0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            level_q   <= level_d;
            lines_q   <= lines_d;
            base_q    <= base_d;
            lc_q      <= lc_d;
            passes_q  <= passes_d;
            dig_q     <= dig_d;
            carry_q   <= carry_d;
            sat_q     <= sat_d;
            pend_q    <= pend_d;
            pend_lc_q <= pend_lc_d;
        end
    end

    // Frame image: title glyph in byte 7, value right-justified, blanks elsewhere.
    always_comb begin
        frame = '1;
        if (mode) begin
            frame[63:56] = SEG_L;
            frame[7:0]   = bcd2seg(level_q);
        end else begin
            frame[63:56] = SEG_S;
            for (int i = 0; i < int'(DIGITS); i++) begin
                frame[8*i +: 8] = bcd2seg(score_q[4*i +: 4]);
            end
        end
    end

    seg_serializer #(
        .CLK_DIV     (CLK_DIV),
        .REFRESH_GAP (REFRESH_GAP)
    ) u_seg_serializer (
        .clk       (clk),
        .rst       (rst),
        .frame_i   (frame),
        .seg_clk_o (SEGCLK),
        .seg_clr_o (SEGCLR),
        .seg_dt_o  (SEGDT),
        .seg_en_o  (SEGEN)
    );

    assign score = score_q;
    assign level = level_q;

endmodule

// File: tb/tb_score_level_display.sv
// Directed self-checking bench for score_level_display.
module tb_score_level_display;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned LPL     = 10;
    localparam int unsigned CDIV    = 2;
    localparam int unsigned GAP     = 16;
    localparam int          GAP_DET = 2 * CDIV + 2;
    localparam int          TMO     = 2000;

    logic                clk;
    logic                rst;
    logic                hit;
    logic [1:0]          lineCount;
    logic                mode;
    logic [4*DIGITS-1:0] score;
    logic [3:0]          level;
    logic                busy;
    logic                SEGCLK, SEGCLR, SEGDT, SEGEN;

    int vectors;
    int miscompares;

    score_level_display #(
        .DIGITS          (DIGITS),
        .LINES_PER_LEVEL (LPL),
        .CLK_DIV         (CDIV),
        .REFRESH_GAP     (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .lineCount (lineCount),
        .mode      (mode),
        .score     (score),
        .level     (level),
        .busy      (busy),
        .SEGCLK    (SEGCLK),
        .SEGCLR    (SEGCLR),
        .SEGDT     (SEGDT),
        .SEGEN     (SEGEN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("busy_settle", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_hit(input logic [1:0] lc);
        @(negedge clk);
        hit       = 1'b1;
        lineCount = lc;
        @(negedge clk);
        hit = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Collects one frame as 64 rising-edge samples, then counts stray extra edges.
    task automatic capture(input bit from_reset, output logic [63:0] f, output int edges);
        int   low_run;
        int   t;
        logic prev;
        f      = '0;
        edges  = 0;
        prev   = 1'b0;
        if (!from_reset) begin
            low_run = 0;
            t       = 0;
            while (low_run < GAP_DET && t < TMO) begin
                @(negedge clk);
                t++;
                if (SEGCLK) low_run = 0;
                else        low_run++;
            end
            if (t >= TMO) begin
                edges = -1;
                return;
            end
        end
        t = 0;
        while (edges < 64 && t < TMO) begin
            @(negedge clk);
            t++;
            if (SEGCLK && !prev) begin
                f = {f[62:0], SEGDT};
                edges++;
            end
            prev = SEGCLK;
        end
        repeat (2 * CDIV + 4) begin
            @(negedge clk);
            if (SEGCLK && !prev) edges++;
            prev = SEGCLK;
        end
    endtask

    initial begin
        logic [63:0] f;
        int          e;
        int          bcnt;
        int          n;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        hit         = 1'b0;
        lineCount   = 2'd0;
        mode        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_score", 64'(score), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_segclk", 64'(SEGCLK), 64'h0);
        chk("rst_segclr", 64'(SEGCLR), 64'h0);
        chk("rst_segdt", 64'(SEGDT), 64'h0);
        chk("rst_segen", 64'(SEGEN), 64'h0);

        // First frame after release
        rst = 1'b0;
        capture(1'b1, f, e);
        chk("frame_first", f, 64'h92FF_FFFF_C0C0_C0C0);
        chk("edges_first", 64'(e), 64'd64);
        chk("segclr_run", 64'(SEGCLR), 64'h1);
        chk("segen_run", 64'(SEGEN), 64'h1);

        // Four-line clear at level 0: busy spans 6 cycles
        wait_idle();
        @(negedge clk);
        hit       = 1'b1;
        lineCount = 2'd3;
        bcnt      = 0;
        #1;
        if (busy) bcnt++;
        @(posedge clk);
        #1;
        hit = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("busy_cycles", 64'(bcnt), 64'd6);
        chk("score_tetris", 64'(score), 64'h0008);
        chk("level_tetris", 64'(level), 64'h0);

        // Ten single lines raise level; next award is scaled by 2
        do_reset();
        repeat (10) do_hit(2'd0);
        chk("score_ten", 64'(score), 64'h0010);
        chk("level_ten", 64'(level), 64'h1);
        do_hit(2'd1);
        chk("score_scaled", 64'(score), 64'h0016);
        chk("level_scaled", 64'(level), 64'h1);

        // Back-to-back hits: second pends, third dropped
        do_reset();
        @(negedge clk);
        hit       = 1'b1;
        lineCount = 2'd1;
        @(negedge clk);
        lineCount = 2'd2;
        @(negedge clk);
        lineCount = 2'd3;
        @(negedge clk);
        hit = 1'b0;
        wait_idle();
        chk("score_pending", 64'(score), 64'h0008);
        chk("level_pending", 64'(level), 64'h0);

        // Climb towards saturation, checking both display views on the way
        do_reset();
        repeat (8) do_hit(2'd3);
        chk("score_l3", 64'(score), 64'h0128);
        chk("level_l3", 64'(level), 64'h3);
        mode = 1'b1;
        capture(1'b0, f, e);
        chk("frame_level", f, 64'hC7FF_FFFF_FFFF_FFB0);
        chk("edges_level", 64'(e), 64'd64);
        mode = 1'b0;
        capture(1'b0, f, e);
        chk("frame_score", f, 64'h92FF_FFFF_C0F9_A480);
        repeat (12) do_hit(2'd3);
        chk("score_l8", 64'(score), 64'h0704);
        chk("level_l8", 64'(level), 64'h8);
        repeat (3) do_hit(2'd2);
        do_hit(2'd0);
        chk("score_l9", 64'(score), 64'h0848);
        chk("level_l9", 64'(level), 64'h9);
        repeat (114) do_hit(2'd3);
        chk("score_9968", 64'(score), 64'h9968);
        do_hit(2'd1);
        chk("score_9998", 64'(score), 64'h9998);
        do_hit(2'd1);
        chk("score_sat", 64'(score), 64'h9999);
        do_hit(2'd3);
        chk("score_sat_hold", 64'(score), 64'h9999);
        chk("level_sat", 64'(level), 64'h9);

        // Reset mid-add and mid-shift while SEGCLK is high
        @(negedge clk);
        hit       = 1'b1;
        lineCount = 2'd3;
        @(negedge clk);
        hit = 1'b0;
        n   = 0;
        while (!SEGCLK && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_busy", 64'(busy), 64'h1);
        chk("pre_rst_segclk", 64'(SEGCLK), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_segclk", 64'(SEGCLK), 64'h0);
        chk("arst_segdt", 64'(SEGDT), 64'h0);
        chk("arst_segclr", 64'(SEGCLR), 64'h0);
        chk("arst_segen", 64'(SEGEN), 64'h0);
        chk("arst_score", 64'(score), 64'h0);
        chk("arst_level", 64'(level), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        capture(1'b1, f, e);
        chk("frame_after_rst", f, 64'h92FF_FFFF_C0C0_C0C0);
        chk("edges_after_rst", 64'(e), 64'd64);
        chk("segclr_after", 64'(SEGCLR), 64'h1);
        chk("segen_after", 64'(SEGEN), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
